// File: rtl/pep_ks_body_ram.sv
// Double-buffered LWE body store between the key switch and the mod-switch side.
// Bodies are captured by (parity, pid) and read back once, optionally mean-corrected.
module pep_ks_body_ram #(
    parameter int PID_W          = 5,
    parameter int MOD_KSK_W      = 21,
    parameter int KS_MAX_ERROR_W = 8
) (
    input  logic                      clk,
    input  logic                      a_rst_n,
    input  logic                      ks_boram_wr_en,
    input  logic [MOD_KSK_W-1:0]      ks_boram_data,
    input  logic [PID_W-1:0]          ks_boram_pid,
    input  logic                      ks_boram_parity,
    input  logic                      ks_boram_corr_wr_en,
    input  logic [KS_MAX_ERROR_W-1:0] ks_boram_corr_data,
    input  logic [PID_W-1:0]          ks_boram_corr_pid,
    input  logic                      boram_rd_en,
    input  logic [PID_W-1:0]          boram_rd_pid,
    input  logic                      boram_rd_parity,
    output logic [MOD_KSK_W-1:0]      boram_rd_data,
    output logic                      boram_rd_data_vld,
    output logic [PID_W-1:0]          boram_rd_pid_out,
    input  logic                      mod_switch_mean_comp,
    input  logic                      reset_cache,
    output logic [2:0]                boram_error
);

    localparam int NSLOT = 2 ** PID_W;
    localparam int EXT_W = MOD_KSK_W - KS_MAX_ERROR_W;

    // Payload memories carry no reset; only the valid bits do.
    logic [MOD_KSK_W-1:0]      body_mem [2][NSLOT];
    logic [KS_MAX_ERROR_W-1:0] corr_mem [NSLOT];

    logic [1:0][NSLOT-1:0] body_vld_q, body_vld_d;
    logic [NSLOT-1:0]      corr_vld_q, corr_vld_d;

    logic wr_ok;
    logic corr_wr_ok;

    // Read stage 1: slot snapshot taken at the edge that accepts the request.
    logic                      s1_vld_q;
    logic [PID_W-1:0]          s1_pid_q;
    logic                      s1_comp_q;
    logic                      s1_body_vld_q;
    logic                      s1_corr_vld_q;
    logic [MOD_KSK_W-1:0]      s1_body_q;
    logic [KS_MAX_ERROR_W-1:0] s1_corr_q;

    // Read stage 2: output registers.
    logic [MOD_KSK_W-1:0] rd_data_q, rd_data_d;
    logic                 rd_vld_q;
    logic [PID_W-1:0]     rd_pid_q;
    logic [2:0]           err_q, err_d;

    logic [MOD_KSK_W-1:0] corr_ext;
    logic [MOD_KSK_W-1:0] corr_sum;

    assign wr_ok      = ks_boram_wr_en & ~reset_cache;
    assign corr_wr_ok = ks_boram_corr_wr_en & ~reset_cache;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            body_mem[ks_boram_parity][ks_boram_pid] <= ks_boram_data;
        end
        if (corr_wr_ok) begin
            corr_mem[ks_boram_corr_pid] <= ks_boram_corr_data;
        end
        s1_body_q <= body_mem[boram_rd_parity][boram_rd_pid];
        s1_corr_q <= corr_mem[boram_rd_pid];
    end

    // A read clears its slot, a same-cycle write sets it again: set wins.
    always_comb begin
        body_vld_d = body_vld_q;
        corr_vld_d = corr_vld_q;
        if (reset_cache) begin
            body_vld_d = '0;
            corr_vld_d = '0;
        end else begin
            if (boram_rd_en) begin
                body_vld_d[boram_rd_parity][boram_rd_pid] = 1'b0;
                if (mod_switch_mean_comp) begin
                    corr_vld_d[boram_rd_pid] = 1'b0;
                end
            end
            if (ks_boram_wr_en) begin
                body_vld_d[ks_boram_parity][ks_boram_pid] = 1'b1;
            end
            if (ks_boram_corr_wr_en) begin
                corr_vld_d[ks_boram_corr_pid] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            body_vld_q    <= '0;
            corr_vld_q    <= '0;
            s1_vld_q      <= 1'b0;
            s1_pid_q      <= '0;
            s1_comp_q     <= 1'b0;
            s1_body_vld_q <= 1'b0;
            s1_corr_vld_q <= 1'b0;
        end else begin
            body_vld_q    <= body_vld_d;
            corr_vld_q    <= corr_vld_d;
            s1_vld_q      <= boram_rd_en;
            s1_pid_q      <= boram_rd_pid;
            s1_comp_q     <= mod_switch_mean_comp;
            s1_body_vld_q <= body_vld_q[boram_rd_parity][boram_rd_pid];
            s1_corr_vld_q <= corr_vld_q[boram_rd_pid];
        end
    end

    // Missing correction counts as zero; the sum wraps modulo 2**MOD_KSK_W.
    assign corr_ext = s1_corr_vld_q ? {{EXT_W{s1_corr_q[KS_MAX_ERROR_W-1]}}, s1_corr_q} : '0;
    assign corr_sum = s1_body_q + corr_ext;

    always_comb begin
        rd_data_d = '0;
        if (s1_vld_q && s1_body_vld_q) begin
            rd_data_d = s1_comp_q ? corr_sum : s1_body_q;
        end
        err_d[0] = wr_ok & body_vld_q[ks_boram_parity][ks_boram_pid];
        err_d[1] = s1_vld_q & ~s1_body_vld_q;
        err_d[2] = s1_vld_q & s1_comp_q & ~s1_corr_vld_q;
    end

    // Request/response: no backpressure; every boram_rd_en cycle yields exactly
    // one boram_rd_data_vld pulse two edges later, in request order.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_pid_q  <= '0;
            err_q     <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_vld_q  <= s1_vld_q;
            rd_pid_q  <= s1_pid_q;
            err_q     <= err_d;
        end
    end

    assign boram_rd_data     = rd_data_q;
    assign boram_rd_data_vld = rd_vld_q;
    assign boram_rd_pid_out  = rd_pid_q;
    assign boram_error       = err_q;

endmodule

// File: tb/tb_pep_ks_body_ram.sv
// Directed and randomised bench for pep_ks_body_ram with a slot-level reference model
// and an expected-read queue drained by an output monitor.
module tb_pep_ks_body_ram;

    logic        clk = 1'b0;
    logic        a_rst_n = 1'b0;
    logic        ks_boram_wr_en = 1'b0;
    logic [20:0] ks_boram_data = '0;
    logic [4:0]  ks_boram_pid = '0;
    logic        ks_boram_parity = 1'b0;
    logic        ks_boram_corr_wr_en = 1'b0;
    logic [7:0]  ks_boram_corr_data = '0;
    logic [4:0]  ks_boram_corr_pid = '0;
    logic        boram_rd_en = 1'b0;
    logic [4:0]  boram_rd_pid = '0;
    logic        boram_rd_parity = 1'b0;
    logic [20:0] boram_rd_data;
    logic        boram_rd_data_vld;
    logic [4:0]  boram_rd_pid_out;
    logic        mod_switch_mean_comp = 1'b0;
    logic        reset_cache = 1'b0;
    logic [2:0]  boram_error;

    pep_ks_body_ram dut (
        .clk                  (clk),
        .a_rst_n              (a_rst_n),
        .ks_boram_wr_en       (ks_boram_wr_en),
        .ks_boram_data        (ks_boram_data),
        .ks_boram_pid         (ks_boram_pid),
        .ks_boram_parity      (ks_boram_parity),
        .ks_boram_corr_wr_en  (ks_boram_corr_wr_en),
        .ks_boram_corr_data   (ks_boram_corr_data),
        .ks_boram_corr_pid    (ks_boram_corr_pid),
        .boram_rd_en          (boram_rd_en),
        .boram_rd_pid         (boram_rd_pid),
        .boram_rd_parity      (boram_rd_parity),
        .boram_rd_data        (boram_rd_data),
        .boram_rd_data_vld    (boram_rd_data_vld),
        .boram_rd_pid_out     (boram_rd_pid_out),
        .mod_switch_mean_comp (mod_switch_mean_comp),
        .reset_cache          (reset_cache),
        .boram_error          (boram_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [20:0] data;
        logic [4:0]  pid;
        logic [2:0]  err;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      e0_q[$];

    int edge_cnt = 0;
    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit mon_en   = 1'b0;

    logic [20:0] m_body [2][32];
    logic        m_bvld [2][32];
    logic [7:0]  m_corr [32];
    logic        m_cvld [32];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Output monitor: pops expected reads and bit0 pulses due at this edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic        exp_vld;
            logic [2:0]  exp_err;
            rd_exp_t     r;
            exp_vld = 1'b0;
            exp_err = 3'b000;
            r = '{0, 21'h0, 5'h0, 3'b000};
            if (rd_q.size() > 0 && rd_q[0].cyc == edge_cnt) begin
                r = rd_q.pop_front();
                exp_vld = 1'b1;
                exp_err = r.err;
            end
            if (e0_q.size() > 0 && e0_q[0] == edge_cnt) begin
                void'(e0_q.pop_front());
                exp_err[0] = 1'b1;
            end
            chk("rd_vld", 32'(boram_rd_data_vld), 32'(exp_vld));
            chk("error", 32'(boram_error), 32'(exp_err));
            if (exp_vld) begin
                chk("rd_data", 32'(boram_rd_data), 32'(r.data));
                chk("rd_pid", 32'(boram_rd_pid_out), 32'(r.pid));
            end
        end
    end

    function automatic logic [20:0] sext8(input logic [7:0] c);
        return c[7] ? {13'h1FFF, c} : {13'h0000, c};
    endfunction

    // Drives one cycle of stimulus at a negedge and updates the reference model.
    task automatic step(input logic wr, input int wpid, input logic wpar, input logic [20:0] wdata,
                        input logic cwr, input int cpid, input logic [7:0] cdata,
                        input logic rd, input int rpid, input logic rpar, input logic rc);
        int      p;
        logic    mc;
        rd_exp_t r;
        ks_boram_wr_en      = wr;
        ks_boram_pid        = 5'(wpid);
        ks_boram_parity     = wpar;
        ks_boram_data       = wdata;
        ks_boram_corr_wr_en = cwr;
        ks_boram_corr_pid   = 5'(cpid);
        ks_boram_corr_data  = cdata;
        boram_rd_en         = rd;
        boram_rd_pid        = 5'(rpid);
        boram_rd_parity     = rpar;
        reset_cache         = rc;
        p  = edge_cnt + 1;
        mc = mod_switch_mean_comp;
        if (rd) begin
            r.cyc  = p + 1;
            r.pid  = 5'(rpid);
            r.err  = {mc && !m_cvld[rpid], !m_bvld[rpar][rpid], 1'b0};
            r.data = 21'h0;
            if (m_bvld[rpar][rpid]) begin
                r.data = m_body[rpar][rpid];
                if (mc && m_cvld[rpid]) r.data = m_body[rpar][rpid] + sext8(m_corr[rpid]);
            end
            rd_q.push_back(r);
        end
        if (wr && !rc && m_bvld[wpar][wpid]) e0_q.push_back(p);
        if (rc) begin
            for (int b = 0; b < 2; b++) for (int i = 0; i < 32; i++) m_bvld[b][i] = 1'b0;
            for (int i = 0; i < 32; i++) m_cvld[i] = 1'b0;
        end else begin
            if (rd) begin
                m_bvld[rpar][rpid] = 1'b0;
                if (mc) m_cvld[rpid] = 1'b0;
            end
            if (wr) begin
                m_bvld[wpar][wpid] = 1'b1;
                m_body[wpar][wpid] = wdata;
            end
            if (cwr) begin
                m_cvld[cpid] = 1'b1;
                m_corr[cpid] = cdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 21'h0, 0, 0, 8'h0, 0, 0, 0, 0);
    endtask

    task automatic wr_body(input int pid, input logic par, input logic [20:0] d);
        step(1, pid, par, d, 0, 0, 8'h0, 0, 0, 0, 0);
    endtask

    task automatic rd_body(input int pid, input logic par);
        step(0, 0, 0, 21'h0, 0, 0, 8'h0, 1, pid, par, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"}, 32'(boram_rd_data), 32'h0);
        chk({tag, "_vld"}, 32'(boram_rd_data_vld), 32'h0);
        chk({tag, "_pid"}, 32'(boram_rd_pid_out), 32'h0);
        chk({tag, "_err"}, 32'(boram_error), 32'h0);
    endtask

    initial begin
        for (int b = 0; b < 2; b++) for (int i = 0; i < 32; i++) m_bvld[b][i] = 1'b0;
        for (int i = 0; i < 32; i++) m_cvld[i] = 1'b0;

        // Power-on reset
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        a_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Basic write then read, no correction
        wr_body(3, 0, 21'h12345);
        idle(1);
        rd_body(3, 0);
        idle(3);

        // Both banks of one pid, back-to-back reads
        wr_body(7, 0, 21'h00010);
        wr_body(7, 1, 21'h00020);
        rd_body(7, 1);
        rd_body(7, 0);
        idle(3);

        // Mean correction with wrap, then re-read of the consumed slot
        mod_switch_mean_comp = 1'b1;
        step(1, 1, 0, 21'h00002, 1, 1, 8'hFC, 0, 0, 0, 0);
        idle(1);
        rd_body(1, 0);
        rd_body(1, 0);
        idle(3);
        mod_switch_mean_comp = 1'b0;
        idle(1);

        // Double write raises bit0; the second value survives
        wr_body(5, 0, 21'h0AAAA);
        wr_body(5, 0, 21'h15555);
        idle(1);
        rd_body(5, 0);
        idle(3);

        // Same-cycle read and write of an empty slot
        step(1, 9, 0, 21'h0ABCD, 0, 0, 8'h0, 1, 9, 0, 0);
        idle(1);
        rd_body(9, 0);
        idle(3);

        // reset_cache drops the same-cycle write and empties all slots
        wr_body(10, 0, 21'h00A0A);
        wr_body(11, 1, 21'h00B0B);
        wr_body(12, 0, 21'h00C0C);
        wr_body(13, 1, 21'h00D0D);
        step(1, 14, 0, 21'h00E0E, 0, 0, 8'h0, 0, 0, 0, 1);
        rd_body(10, 0);
        rd_body(11, 1);
        rd_body(12, 0);
        rd_body(13, 1);
        rd_body(14, 0);
        idle(3);

        // Randomised traffic on a few pids to provoke collisions, correction enabled
        mod_switch_mean_comp = 1'b1;
        idle(1);
        for (int k = 0; k < 40; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 21'($urandom_range(0, 21'h1FFFFF)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end
        idle(3);
        mod_switch_mean_comp = 1'b0;
        idle(1);

        // Reset one cycle after a read request kills the in-flight read
        wr_body(20, 1, 21'h1ABCD);
        idle(1);
        rd_body(20, 1);
        mon_en = 1'b0;
        boram_rd_en = 1'b0;
        a_rst_n = 1'b0;
        rd_q.delete();
        e0_q.delete();
        for (int b = 0; b < 2; b++) for (int i = 0; i < 32; i++) m_bvld[b][i] = 1'b0;
        for (int i = 0; i < 32; i++) m_cvld[i] = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk);
        chk_outputs_zero("midrst_hold");
        a_rst_n = 1'b1;
        mon_en  = 1'b1;
        idle(3);
        rd_body(20, 1);
        idle(3);

        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        chk("err0_queue_drained", 32'(e0_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pep_ks_body_ram.md
Name: pep_ks_body_ram

Overview:
- Double-buffered body store sitting directly downstream of the key-switch stage in the PBS processing element.
- Captures each LWE body produced by the key switch, indexed by PID and batch parity.
- Optionally adds the per-PID mean-correction term on read.
- Serves bodies to the mod-switch/accumulator side through a fixed-latency read port with slot-occupancy tracking and error reporting.

Parameters:
- PID_W, 5: PID index width; 2**PID_W slots per parity bank.
- MOD_KSK_W, 21: body coefficient width.
- KS_MAX_ERROR_W, 8: signed mean-correction width (two's complement).

Ports:
- clk  in  1  clock.
- a_rst_n  in  1  asynchronous active-low reset.
- ks_boram_wr_en  in  1  body write strobe.
- ks_boram_data  in  MOD_KSK_W  body value.
- ks_boram_pid  in  PID_W  body slot.
- ks_boram_parity  in  1  bank select.
- ks_boram_corr_wr_en  in  1  correction write strobe.
- ks_boram_corr_data  in  KS_MAX_ERROR_W  signed correction.
- ks_boram_corr_pid  in  PID_W  correction slot.
- boram_rd_en  in  1  read request.
- boram_rd_pid  in  PID_W  read slot.
- boram_rd_parity  in  1  read bank.
- boram_rd_data  out  MOD_KSK_W  body (corrected when enabled).
- boram_rd_data_vld  out  1  read data qualifier.
- boram_rd_pid_out  out  PID_W  PID echoed with the data.
- mod_switch_mean_comp  in  1  correction enable, quasi-static.
- reset_cache  in  1  invalidates all slots.
- boram_error  out  3  bit0 write to valid slot, bit1 read of empty slot, bit2 missing correction.

Behaviour:
- Storage: body[2][2**PID_W], body_vld[2][2**PID_W], corr[2**PID_W], corr_vld[2**PID_W]. Memory contents are not reset; valid bits are.
- Reset: all valid bits 0; boram_rd_data, boram_rd_data_vld, boram_rd_pid_out and boram_error are 0. Reset asserted mid-read kills the in-flight read and no vld pulse follows.
- Body write, cycle N: body[parity][pid] <= data; body_vld <= 1.
  - If the slot was already valid: write still occurs; error bit0 pulses at N+1.
- Correction write: corr[pid] <= data; corr_vld[pid] <= 1. Overwrite is silent.
- Read request at cycle N (no backpressure; one request per cycle allowed):
  - N+1: slot content and valid bits are sampled into pipeline stage 1.
  - N+2: boram_rd_data_vld=1, boram_rd_data and boram_rd_pid_out presented. Latency is fixed at 2 and reads are fully pipelined.
  - Read data = body when mod_switch_mean_comp=0.
  - Read data = (body + sign_extend(corr)) mod 2**MOD_KSK_W when mod_switch_mean_comp=1. The addition wraps and carry is discarded.
  - A read consumes the slot: body_vld cleared. With mean_comp=1, corr_vld[pid] is also cleared.
  - Slot empty at request: vld still pulses, data is 0, error bit1 pulses with the data (N+2).
  - mean_comp=1 and corr_vld=0: correction treated as 0, error bit2 pulses at N+2.
- Simultaneous write and read of the same body slot in cycle N:
  - The read observes pre-write state.
  - The slot ends valid with the new data (set wins over clear).
  - Error bit0 is evaluated on pre-cycle valid.
- Same rule for a correction write plus a read of the same PID: the read uses the old correction and the new correction remains valid.
- Different slots are fully independent; both banks are usable concurrently.
- reset_cache:
  - Clears all body_vld and corr_vld at the next edge.
  - Writes in the same cycle are dropped; reads in the same cycle are served from pre-clear state.
  - The pipeline is not flushed.
- boram_error bits are single-cycle registered pulses; multiple bits may be set in the same cycle.

Test Plan:
- Write pid=3 par=0 data=0x12345, mean_comp=0; read pid=3 par=0 two cycles later -> vld at N+2, data=0x12345, pid_out=3, error=0.
- Write pid=7 par=0 =0x00010 and pid=7 par=1 =0x00020; read par=1 then par=0 back-to-back -> 0x00020 then 0x00010 on consecutive cycles.
- mean_comp=1, body pid=1 =0x00002, corr pid=1 =8'hFC (-4) -> read returns 0x1FFFFE (wrap); second read of the same slot -> data 0, error=3'b110.
- Write pid=5 twice without a read -> error=3'b001 one cycle after the second write; subsequent read returns the second value.
- Read and write pid=9 par=0 in the same cycle on an empty slot -> read errors with bit1; next read returns the written data with no error.
- reset_cache after filling 4 slots -> all reads error with bit1. Separately, assert a_rst_n low one cycle after a read request -> no vld and all outputs 0.
